// File: rtl/div_mae_accumulator.sv
// ---------------------------------------------------------------------------
// div_mae_accumulator
//
// Measures the accuracy of an approximate 16/8 divider. Each accepted sample
// carries the dividend/divisor fed to the approximate unit together with its
// quotient/remainder. The block recomputes the exact result with an 8-cycle
// restoring divider and accumulates error statistics over a run of
// NUM_SAMPLES samples.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse: clear statistics and begin a run
//   in_valid     sample offered
//   in_ready     sample accepted this cycle when in_valid is also high
//   n, d         dividend / divisor given to the approximate divider
//   q_apx, r_apx approximate quotient / remainder under test
//   busy         run in progress (RUN, DIV, ACC)
//   done         run complete, held until the next start
//   sample_cnt   accepted samples (including skipped ones)
//   skip_cnt     accepted samples whose quotient would overflow 8 bits
//   err_sum      saturating sum of |q_exact - q_apx|
//   max_err      largest |q_exact - q_apx|
//   mismatch_cnt samples where q or r differ from the exact result
// ---------------------------------------------------------------------------
module div_mae_accumulator #(
  parameter int NUM_SAMPLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] n,
  input  logic [7:0]  d,
  input  logic [7:0]  q_apx,
  input  logic [7:0]  r_apx,
  output logic        busy,
  output logic        done,
  output logic [15:0] sample_cnt,
  output logic [15:0] skip_cnt,
  output logic [31:0] err_sum,
  output logic [7:0]  max_err,
  output logic [15:0] mismatch_cnt
);

  localparam logic [15:0] NS16 = 16'(NUM_SAMPLES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DIV  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_sample_cnt;
  logic [15:0] r_skip_cnt;
  logic [31:0] r_err_sum;
  logic [7:0]  r_max_err;
  logic [15:0] r_mismatch_cnt;

  // Captured operands and divider datapath
  logic [7:0]  r_d;
  logic [7:0]  r_q_apx;
  logic [7:0]  r_r_apx;
  logic [7:0]  r_n_lo;
  logic [7:0]  r_rem;
  logic [7:0]  r_quo;
  logic [2:0]  r_iter;

  logic        w_accept;
  logic        w_skip;
  logic [15:0] w_cnt_inc;
  logic        w_last;
  logic [8:0]  w_trial;
  logic        w_ge;
  logic [8:0]  w_sub;
  logic [7:0]  w_rem_next;
  logic [7:0]  w_err;
  logic [32:0] w_sum_ext;
  logic [31:0] w_sum_sat;
  logic        w_mismatch;

  // in_ready is only ever high in RUN, so it doubles as the accept qualifier
  assign w_accept  = in_valid && r_in_ready;
  // Quotient would not fit in 8 bits (or divide by zero): exclude from metrics
  assign w_skip    = (d == 8'd0) || (n[15:8] >= d);
  assign w_cnt_inc = r_sample_cnt + 16'd1;
  assign w_last    = (w_cnt_inc == NS16);

  // One restoring step. The partial remainder is always < d, so after the
  // shift it fits in 9 bits and the new remainder fits back into 8 bits.
  assign w_trial    = {r_rem, r_n_lo[7]};
  assign w_ge       = (w_trial >= {1'b0, r_d});
  assign w_sub      = w_trial - {1'b0, r_d};
  assign w_rem_next = w_ge ? w_sub[7:0] : w_trial[7:0];

  assign w_err      = (r_quo >= r_q_apx) ? (r_quo - r_q_apx) : (r_q_apx - r_quo);
  assign w_sum_ext  = {1'b0, r_err_sum} + {25'd0, w_err};
  assign w_sum_sat  = w_sum_ext[32] ? 32'hFFFF_FFFF : w_sum_ext[31:0];
  assign w_mismatch = (r_q_apx != r_quo) || (r_r_apx != r_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sample_cnt   <= '0;
      r_skip_cnt     <= '0;
      r_err_sum      <= '0;
      r_max_err      <= '0;
      r_mismatch_cnt <= '0;
      r_d            <= '0;
      r_q_apx        <= '0;
      r_r_apx        <= '0;
      r_n_lo         <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_iter         <= '0;
    end else if (start) begin
      // start overrides every state, abandoning any division in flight
      r_state        <= RUN;
      r_in_ready     <= 1'b1;
      r_busy         <= 1'b1;
      r_done         <= 1'b0;
      r_sample_cnt   <= '0;
      r_skip_cnt     <= '0;
      r_err_sum      <= '0;
      r_max_err      <= '0;
      r_mismatch_cnt <= '0;
      r_iter         <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept) begin
            if (w_skip) begin
              r_sample_cnt <= w_cnt_inc;
              r_skip_cnt   <= r_skip_cnt + 16'd1;
              if (w_last) begin
                r_state    <= DONE;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end
            end else begin
              r_d        <= d;
              r_q_apx    <= q_apx;
              r_r_apx    <= r_apx;
              r_rem      <= n[15:8];
              r_n_lo     <= n[7:0];
              r_quo      <= '0;
              r_iter     <= '0;
              r_state    <= DIV;
              r_in_ready <= 1'b0;
            end
          end
        end
        DIV: begin
          r_rem  <= w_rem_next;
          r_quo  <= {r_quo[6:0], w_ge};
          r_n_lo <= {r_n_lo[6:0], 1'b0};
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_state <= ACC;
          end
        end
        ACC: begin
          r_err_sum    <= w_sum_sat;
          r_sample_cnt <= w_cnt_inc;
          if (w_err > r_max_err) begin
            r_max_err <= w_err;
          end
          if (w_mismatch) begin
            r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
          end
          if (w_last) begin
            r_state    <= DONE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_state    <= RUN;
            r_in_ready <= 1'b1;
          end
        end
        IDLE, DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_cnt   = r_sample_cnt;
  assign skip_cnt     = r_skip_cnt;
  assign err_sum      = r_err_sum;
  assign max_err      = r_max_err;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule

// File: tb/tb_div_mae_accumulator.sv
// ---------------------------------------------------------------------------
// tb_div_mae_accumulator
//
// Self-checking bench. dut runs with the default run length; dut2 uses
// NUM_SAMPLES=2 to reach DONE. Expected statistics come from a behavioural
// model using the native / and % operators and are queued per sample, then
// popped when the DUT is ready again.
// ---------------------------------------------------------------------------
module tb_div_mae_accumulator;

  typedef struct packed {
    logic [15:0] smp;
    logic [15:0] skp;
    logic [31:0] esum;
    logic [7:0]  emax;
    logic [15:0] mis;
  } stats_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic        in_valid, in_valid2;
  logic [15:0] n;
  logic [7:0]  d, q_apx, r_apx;

  logic        in_ready, busy, done;
  logic [15:0] sample_cnt, skip_cnt, mismatch_cnt;
  logic [31:0] err_sum;
  logic [7:0]  max_err;

  logic        in_ready2, busy2, done2;
  logic [15:0] sample_cnt2, skip_cnt2, mismatch_cnt2;
  logic [31:0] err_sum2;
  logic [7:0]  max_err2;

  int checks = 0;
  int passes = 0;

  stats_t sb[$];
  stats_t m;       // model of dut statistics
  stats_t exp_s;
  stats_t obs_s;
  int     lat;

  always #5 clk = ~clk;

  div_mae_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .skip_cnt(skip_cnt),
    .err_sum(err_sum), .max_err(max_err), .mismatch_cnt(mismatch_cnt)
  );

  div_mae_accumulator #(.NUM_SAMPLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
    .in_ready(in_ready2), .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx),
    .busy(busy2), .done(done2), .sample_cnt(sample_cnt2), .skip_cnt(skip_cnt2),
    .err_sum(err_sum2), .max_err(max_err2), .mismatch_cnt(mismatch_cnt2)
  );

  function automatic stats_t cur_stats();
    return {sample_cnt, skip_cnt, err_sum, max_err, mismatch_cnt};
  endfunction

  function automatic int exp_latency(input logic [15:0] nn, input logic [7:0] dd);
    return ((dd == 8'd0) || (nn[15:8] >= dd)) ? 1 : 10;
  endfunction

  task automatic model_push(input logic [15:0] nn, input logic [7:0] dd,
                            input logic [7:0] qq, input logic [7:0] rr);
    int qe, re, e;
    m.smp = m.smp + 16'd1;
    if ((dd == 8'd0) || (nn[15:8] >= dd)) begin
      m.skp = m.skp + 16'd1;
    end else begin
      qe = int'(nn) / int'(dd);
      re = int'(nn) % int'(dd);
      e  = (qe > int'(qq)) ? qe - int'(qq) : int'(qq) - qe;
      m.esum = m.esum + 32'(e);
      if (e > int'(m.emax)) m.emax = 8'(e);
      if ((qe != int'(qq)) || (re != int'(rr))) m.mis = m.mis + 16'd1;
    end
    sb.push_back(m);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m = '0;
    sb.delete();
  endtask

  // Offers one sample to dut as soon as it is ready, then counts negedges
  // until in_ready returns. lat = -1 on any timeout.
  task automatic drive_sample(input logic [15:0] nn, input logic [7:0] dd,
                              input logic [7:0] qq, input logic [7:0] rr,
                              output int lt);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      lt = -1;
      return;
    end
    n = nn; d = dd; q_apx = qq; r_apx = rr;
    in_valid = 1'b1;
    model_push(nn, dd, qq, rr);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lt = 0;
    while (lt < 30) begin
      @(negedge clk);
      lt++;
      if (in_ready) break;
    end
    if (!in_ready) lt = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, busy, done, cur_stats()} !== '0) begin
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b stats=%h, need all zero",
               in_ready, busy, done, cur_stats());
    end else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      $display("FAIL idle_after_reset: got rdy=%b busy=%b done=%b, need 000",
               in_ready, busy, done);
    end else passes++;
  endtask

  task automatic test_exact();
    pulse_start();
    @(negedge clk);
    checks++;
    if ({in_ready, busy, done} !== 3'b110) begin
      $display("FAIL run_flags: got rdy=%b busy=%b done=%b, need 110", in_ready, busy, done);
    end else passes++;
    drive_sample(16'h0064, 8'd7, 8'd14, 8'd2, lat);
    checks++;
    if (lat !== 10) $display("FAIL exact_latency: got %0d, need 10", lat);
    else passes++;
    exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
    obs_s = cur_stats();
    checks++;
    if (obs_s !== exp_s) $display("FAIL exact_stats: got %h, need %h", obs_s, exp_s);
    else passes++;
    $display("sample n=0064 d=7 q=14 r=2 lat=%0d stats=%h", lat, obs_s);
  endtask

  task automatic test_error();
    drive_sample(16'h0064, 8'd7, 8'd12, 8'd2, lat);
    exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
    obs_s = cur_stats();
    checks++;
    if (obs_s !== exp_s) $display("FAIL error_stats: got %h, need %h", obs_s, exp_s);
    else passes++;
    checks++;
    if ({err_sum, max_err, mismatch_cnt} !== {32'd2, 8'd2, 16'd1})
      $display("FAIL error_values: got esum=%0d max=%0d mis=%0d, need 2 2 1",
               err_sum, max_err, mismatch_cnt);
    else passes++;
    $display("sample n=0064 d=7 q=12 r=2 lat=%0d stats=%h", lat, obs_s);
  endtask

  task automatic test_skip();
    logic [15:0] sn [2];
    logic [7:0]  sd [2];
    pulse_start();
    sn[0] = 16'h1234; sd[0] = 8'd0;
    sn[1] = 16'h0900; sd[1] = 8'd8;
    for (int i = 0; i < 2; i++) begin
      drive_sample(sn[i], sd[i], 8'd5, 8'd5, lat);
      checks++;
      if (lat !== 1) $display("FAIL skip_ready: got latency %0d, need 1", lat);
      else passes++;
      exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
      obs_s = cur_stats();
      checks++;
      if (obs_s !== exp_s) $display("FAIL skip_stats: got %h, need %h", obs_s, exp_s);
      else passes++;
      $display("skip n=%h d=%0d lat=%0d stats=%h", sn[i], sd[i], lat, obs_s);
    end
    checks++;
    if ({sample_cnt, skip_cnt, err_sum, max_err, mismatch_cnt} !== {16'd2, 16'd2, 32'd0, 8'd0, 16'd0})
      $display("FAIL skip_values: got smp=%0d skp=%0d esum=%0d, need 2 2 0",
               sample_cnt, skip_cnt, err_sum);
    else passes++;
  endtask

  task automatic test_ignored_valid();
    // in_valid with garbage while the divider is busy must be ignored
    drive_sample(16'h00FF, 8'd16, 8'd15, 8'd15, lat);
    exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
    obs_s = cur_stats();
    checks++;
    if (obs_s !== exp_s) $display("FAIL base_stats: got %h, need %h", obs_s, exp_s);
    else passes++;
    @(negedge clk);
    n = 16'h00C8; d = 8'd9; q_apx = 8'd22; r_apx = 8'd2;
    in_valid = 1'b1;
    model_push(16'h00C8, 8'd9, 8'd22, 8'd2);
    @(posedge clk);
    #1 n = 16'hFFFF; d = 8'd0; q_apx = 8'hAA; r_apx = 8'h55;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!in_ready && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
    obs_s = cur_stats();
    checks++;
    if (obs_s !== exp_s) $display("FAIL ignored_valid_stats: got %h, need %h", obs_s, exp_s);
    else passes++;
    $display("sample n=00c8 d=9 q=22 r=2 with busy-time valid stats=%h", obs_s);
  endtask

  task automatic test_back_to_back();
    logic [15:0] nn;
    logic [7:0]  dd, qq, rr;
    int qe, re, delta;
    for (int i = 0; i < 24; i++) begin
      dd = 8'($urandom_range(1, 255));
      if (i % 6 == 5) nn = {8'($urandom_range(int'(dd), 255)), 8'($urandom_range(0, 255))};
      else            nn = {8'($urandom_range(0, int'(dd) - 1)), 8'($urandom_range(0, 255))};
      qe = int'(nn) / int'(dd);
      re = int'(nn) % int'(dd);
      delta = int'($urandom_range(0, 12)) - 6;
      qe = qe + delta;
      if (qe < 0) qe = 0;
      if (qe > 255) qe = 255;
      qq = 8'(qe);
      rr = ($urandom_range(0, 3) == 0) ? 8'(re) ^ 8'h01 : 8'(re);
      drive_sample(nn, dd, qq, rr, lat);
      checks++;
      if (lat !== exp_latency(nn, dd))
        $display("FAIL b2b_latency: n=%h d=%0d got %0d, need %0d", nn, dd, lat, exp_latency(nn, dd));
      else passes++;
      exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
      obs_s = cur_stats();
      checks++;
      if (obs_s !== exp_s) $display("FAIL b2b_stats: n=%h d=%0d got %h, need %h", nn, dd, obs_s, exp_s);
      else passes++;
      $display("sample n=%h d=%0d q=%0d r=%0d lat=%0d stats=%h", nn, dd, qq, rr, lat, obs_s);
    end
  endtask

  task automatic test_done();
    int w;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = 0;
      @(negedge clk);
      while (!in_ready2 && w < 50) begin @(negedge clk); w++; end
      n = 16'h0064; d = 8'd7; q_apx = 8'd14; r_apx = 8'd2;
      in_valid2 = 1'b1;
      @(posedge clk);
      #1 in_valid2 = 1'b0;
    end
    w = 0;
    while (!done2 && w < 30) begin @(negedge clk); w++; end
    checks++;
    if (w !== 10) $display("FAIL done_latency: got %0d, need 10", w);
    else passes++;
    checks++;
    if ({done2, busy2, in_ready2, sample_cnt2} !== {3'b100, 16'd2})
      $display("FAIL done_flags: got done=%b busy=%b rdy=%b smp=%0d, need 1 0 0 2",
               done2, busy2, in_ready2, sample_cnt2);
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if ({done2, in_ready2} !== 2'b10)
      $display("FAIL done_hold: got done=%b rdy=%b, need 1 0", done2, in_ready2);
    else passes++;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    checks++;
    if ({done2, busy2, in_ready2, sample_cnt2} !== {3'b011, 16'd0})
      $display("FAIL restart_flags: got done=%b busy=%b rdy=%b smp=%0d, need 0 1 1 0",
               done2, busy2, in_ready2, sample_cnt2);
    else passes++;
    // two skipped samples must also complete the run
    for (int i = 0; i < 2; i++) begin
      n = 16'h0100; d = 8'd0;
      in_valid2 = 1'b1;
      @(posedge clk);
      #1 in_valid2 = 1'b0;
      @(negedge clk);
    end
    checks++;
    if ({done2, busy2, skip_cnt2, sample_cnt2} !== {2'b10, 16'd2, 16'd2})
      $display("FAIL skip_done: got done=%b busy=%b skp=%0d smp=%0d, need 1 0 2 2",
               done2, busy2, skip_cnt2, sample_cnt2);
    else passes++;
    $display("dut2 run of 2 complete done=%b", done2);
  endtask

  task automatic test_reset_mid_div();
    pulse_start();
    @(negedge clk);
    n = 16'h0064; d = 8'd7; q_apx = 8'd1; r_apx = 8'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done, cur_stats()} !== '0)
      $display("FAIL async_reset: got rdy=%b busy=%b done=%b stats=%h, need all zero",
               in_ready, busy, done, cur_stats());
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    m = '0;
    sb.delete();
    repeat (14) @(negedge clk);
    checks++;
    if ({in_ready, busy, done, cur_stats()} !== '0)
      $display("FAIL post_reset_idle: got rdy=%b busy=%b done=%b stats=%h, need all zero",
               in_ready, busy, done, cur_stats());
    else passes++;
    $display("reset during DIV handled");
  endtask

  task automatic test_start_abort();
    pulse_start();
    drive_sample(16'h0064, 8'd7, 8'd17, 8'd2, lat);
    exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
    obs_s = cur_stats();
    checks++;
    if (obs_s !== exp_s) $display("FAIL abort_pre_stats: got %h, need %h", obs_s, exp_s);
    else passes++;
    @(negedge clk);
    n = 16'h00FA; d = 8'd3; q_apx = 8'd0; r_apx = 8'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    pulse_start();
    @(negedge clk);
    checks++;
    if ({in_ready, busy, cur_stats()} !== {2'b11, 88'd0})
      $display("FAIL abort_clear: got rdy=%b busy=%b stats=%h, need 1 1 zero",
               in_ready, busy, cur_stats());
    else passes++;
    repeat (12) @(negedge clk);
    checks++;
    if ({in_ready, cur_stats()} !== {1'b1, 88'd0})
      $display("FAIL abort_no_update: got rdy=%b stats=%h, need 1 zero", in_ready, cur_stats());
    else passes++;
    drive_sample(16'h0050, 8'd9, 8'd8, 8'd8, lat);
    exp_s = (sb.size() > 0) ? sb.pop_front() : 'x;
    obs_s = cur_stats();
    checks++;
    if (obs_s !== exp_s) $display("FAIL abort_resume: got %h, need %h", obs_s, exp_s);
    else passes++;
    $display("start abort then sample n=0050 d=9 stats=%h", obs_s);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    in_valid = 1'b0; in_valid2 = 1'b0;
    n = '0; d = '0; q_apx = '0; r_apx = '0;
    m = '0;
    test_reset();
    test_exact();
    test_error();
    test_skip();
    test_ignored_valid();
    test_back_to_back();
    test_done();
    test_reset_mid_div();
    test_start_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
